// File: rtl/prox_estado.sv
// prox_estado: next-state generator for the 2-bit control FSM.
//
// Synchronizes and edge-detects the push-button, synchronizes the abort
// line, runs a per-state dwell timer and decodes the next state from the
// current state (looped back from the external state register) and those
// events.
//
// Ports:
//   clock   in  single clock, rising edge
//   reset   in  asynchronous, active-high; clears every flop
//   botao   in  asynchronous push-button level
//   cancela in  asynchronous abort level
//   ea0/ea1 in  current state bits, from the state register
//   pe0/pe1 out next state bits, to the state register
//   tmo     out one-cycle pulse when the dwell timer expires in A or B
//
// state | meaning
// ------+-----------------------------------------------
// IDLE  | 00, waiting for a button press
// ST_A  | 01, timed dwell of T_A cycles, then B
// ST_B  | 10, timed dwell of T_B cycles, then C
// ST_C  | 11, holds until the next button press

module prox_estado #(
  parameter int T_A = 4,
  parameter int T_B = 8,
  parameter int CW  = 8
) (
  input  logic clock,
  input  logic reset,
  input  logic botao,
  input  logic cancela,
  input  logic ea0,
  input  logic ea1,
  output logic pe0,
  output logic pe1,
  output logic tmo
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    ST_A = 2'b01,
    ST_B = 2'b10,
    ST_C = 2'b11
  } estado_t;

  localparam logic [CW-1:0] LIM_A   = CW'(T_A - 1);
  localparam logic [CW-1:0] LIM_B   = CW'(T_B - 1);
  localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};

  estado_t       ea;
  estado_t       pe;
  logic          b1, b2, b3;
  logic          c1, c2;
  logic [1:0]    ea_prev;
  logic [CW-1:0] cnt;
  logic [CW-1:0] dwell;
  logic          entry;
  logic          btn_edge;
  logic          cancela_s;
  logic          tmo_raw;

  assign ea = estado_t'({ea1, ea0});

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      b1      <= 1'b0;
      b2      <= 1'b0;
      b3      <= 1'b0;
      c1      <= 1'b0;
      c2      <= 1'b0;
      ea_prev <= 2'b00;
      cnt     <= '0;
    end else begin
      b1      <= botao;
      b2      <= b1;
      b3      <= b2;
      c1      <= cancela;
      c2      <= c1;
      ea_prev <= {ea1, ea0};
      // saturate so a long stay never wraps back onto a timeout value
      cnt     <= (dwell == CNT_MAX) ? dwell : dwell + CW'(1);
    end
  end

  assign btn_edge  = b2 & ~b3;
  assign cancela_s = c2;

  // any change of the looped-back state restarts the dwell count at 0
  assign entry = ({ea1, ea0} != ea_prev);
  assign dwell = entry ? '0 : cnt;

  assign tmo_raw = ((ea == ST_A) && (dwell == LIM_A)) ||
                   ((ea == ST_B) && (dwell == LIM_B));

  // gated by reset so the output is quiet even with a nonzero ea during reset
  assign tmo = tmo_raw & ~reset;

  always_comb begin
    pe = ea;
    if (reset) begin
      pe = IDLE;
    end else if (cancela_s) begin
      pe = IDLE;
    end else begin
      case (ea)
        IDLE: pe = btn_edge ? ST_A : IDLE;
        ST_A: begin
          if (btn_edge)     pe = ST_C;
          else if (tmo_raw) pe = ST_B;
          else              pe = ST_A;
        end
        ST_B: begin
          if (btn_edge)     pe = ST_A;
          else if (tmo_raw) pe = ST_C;
          else              pe = ST_B;
        end
        ST_C: pe = btn_edge ? IDLE : ST_C;
        default: pe = IDLE;
      endcase
    end
  end

  assign {pe1, pe0} = pe;

endmodule

// File: tb/tb_prox_estado.sv
module tb_prox_estado;

  logic       clock = 1'b0;
  logic       reset;
  logic       botao, cancela;
  logic       botao2;
  logic       pe0, pe1, tmo;
  logic       pe0_2, pe1_2, tmo2;
  logic [1:0] ea, ea2;
  logic [1:0] pe, pe2;

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  prox_estado dut (
    .clock  (clock),
    .reset  (reset),
    .botao  (botao),
    .cancela(cancela),
    .ea0    (ea[0]),
    .ea1    (ea[1]),
    .pe0    (pe0),
    .pe1    (pe1),
    .tmo    (tmo)
  );

  prox_estado #(.T_A(7), .T_B(7), .CW(3)) dut2 (
    .clock  (clock),
    .reset  (reset),
    .botao  (botao2),
    .cancela(1'b0),
    .ea0    (ea2[0]),
    .ea1    (ea2[1]),
    .pe0    (pe0_2),
    .pe1    (pe1_2),
    .tmo    (tmo2)
  );

  assign pe  = {pe1, pe0};
  assign pe2 = {pe1_2, pe0_2};

  // model of the external 2-bit state registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ea  <= 2'b00;
      ea2 <= 2'b00;
    end else begin
      ea  <= pe;
      ea2 <= pe2;
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // one-cycle button pulse; edge is high in the cycle after the second tick
  task automatic press_pulse();
    botao = 1'b1;
    tick();
    botao = 1'b0;
    tick();
  endtask

  initial begin
    reset   = 1'b1;
    botao   = 1'b0;
    cancela = 1'b0;
    botao2  = 1'b0;
    #2;
    chk("rst_pe", 8'(pe), 8'h0);
    chk("rst_tmo", 8'(tmo), 8'h0);
    chk("rst_ea", 8'(ea), 8'h0);
    tick();
    tick();
    reset = 1'b0;

    // 1: quiet inputs keep IDLE
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("idle_pe", 8'(pe), 8'h0);
      chk("idle_tmo", 8'(tmo), 8'h0);
    end

    // 2: held press, full A -> B -> C sequence
    botao = 1'b1;
    tick();
    chk("p2_pe_k", 8'(pe), 8'h0);
    tick();
    chk("p2_pe_edge", 8'(pe), 8'h1);
    chk("p2_ea_edge", 8'(ea), 8'h0);
    tick();
    chk("p2_ea_a", 8'(ea), 8'h1);
    chk("p2_tmo_a1", 8'(tmo), 8'h0);
    tick();
    chk("p2_tmo_a2", 8'(tmo), 8'h0);
    tick();
    chk("p2_tmo_a3", 8'(tmo), 8'h0);
    botao = 1'b0;
    tick();
    chk("p2_tmo_a4", 8'(tmo), 8'h1);
    chk("p2_pe_a4", 8'(pe), 8'h2);
    tick();
    chk("p2_ea_b", 8'(ea), 8'h2);
    chk("p2_tmo_b1", 8'(tmo), 8'h0);
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("p2_b_ea", 8'(ea), 8'h2);
      chk("p2_b_tmo", 8'(tmo), 8'h0);
    end
    tick();
    chk("p2_tmo_b8", 8'(tmo), 8'h1);
    chk("p2_pe_b8", 8'(pe), 8'h3);
    tick();
    chk("p2_ea_c", 8'(ea), 8'h3);
    for (int i = 0; i < 40; i++) begin
      tick();
      chk("p2_c_ea", 8'(ea), 8'h3);
      chk("p2_c_tmo", 8'(tmo), 8'h0);
    end

    // 3a: C -> IDLE, then edge in A dwell cycle 2 -> C, no timeout
    press_pulse();
    chk("p3_pe_idle", 8'(pe), 8'h0);
    tick();
    chk("p3_ea_idle", 8'(ea), 8'h0);
    tick();
    botao = 1'b1;
    tick();
    botao = 1'b0;
    tick();
    chk("p3a_pe_a", 8'(pe), 8'h1);
    botao = 1'b1;
    tick();
    chk("p3a_ea_a", 8'(ea), 8'h1);
    chk("p3a_pe_a1", 8'(pe), 8'h1);
    botao = 1'b0;
    tick();
    chk("p3a_pe_c", 8'(pe), 8'h3);
    chk("p3a_tmo2", 8'(tmo), 8'h0);
    tick();
    chk("p3a_ea_c", 8'(ea), 8'h3);
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("p3a_c_ea", 8'(ea), 8'h3);
      chk("p3a_c_tmo", 8'(tmo), 8'h0);
    end

    // 3b: edge coincident with A dwell cycle 4 -> C wins over B
    press_pulse();
    tick();
    chk("p3b_ea_idle", 8'(ea), 8'h0);
    tick();
    press_pulse();
    chk("p3b_pe_a", 8'(pe), 8'h1);
    tick();
    chk("p3b_ea_a", 8'(ea), 8'h1);
    tick();
    chk("p3b_tmo2", 8'(tmo), 8'h0);
    botao = 1'b1;
    tick();
    chk("p3b_tmo3", 8'(tmo), 8'h0);
    botao = 1'b0;
    tick();
    chk("p3b_tmo4", 8'(tmo), 8'h1);
    chk("p3b_pe_c", 8'(pe), 8'h3);
    tick();
    chk("p3b_ea_c", 8'(ea), 8'h3);

    // 4: abort in B dwell cycle 3, presses ignored while aborting
    tick();
    press_pulse();
    tick();
    chk("p4_ea_idle", 8'(ea), 8'h0);
    tick();
    press_pulse();
    chk("p4_pe_a", 8'(pe), 8'h1);
    tick();
    chk("p4_ea_a", 8'(ea), 8'h1);
    tick();
    tick();
    tick();
    chk("p4_tmo_a4", 8'(tmo), 8'h1);
    chk("p4_pe_b", 8'(pe), 8'h2);
    tick();
    chk("p4_ea_b", 8'(ea), 8'h2);
    tick();
    cancela = 1'b1;
    tick();
    chk("p4_pe_k", 8'(pe), 8'h2);
    tick();
    chk("p4_pe_k1", 8'(pe), 8'h0);
    chk("p4_tmo_k1", 8'(tmo), 8'h0);
    tick();
    chk("p4_ea_k2", 8'(ea), 8'h0);
    for (int p = 0; p < 2; p++) begin
      botao = 1'b1;
      tick();
      chk("p4_ab_pe", 8'(pe), 8'h0);
      botao = 1'b0;
      tick();
      chk("p4_ab_pe_edge", 8'(pe), 8'h0);
      tick();
      chk("p4_ab_ea", 8'(ea), 8'h0);
    end
    cancela = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("p4_rel_ea", 8'(ea), 8'h0);
    end

    // 5: asynchronous reset mid-cycle in B with cnt=5
    press_pulse();
    chk("p5_pe_a", 8'(pe), 8'h1);
    tick();
    chk("p5_ea_a", 8'(ea), 8'h1);
    tick();
    tick();
    tick();
    chk("p5_tmo_a4", 8'(tmo), 8'h1);
    tick();
    chk("p5_ea_b", 8'(ea), 8'h2);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("p5_b_tmo", 8'(tmo), 8'h0);
    end
    chk("p5_pe_b", 8'(pe), 8'h2);
    chk("p5_cnt5", 8'(dut.cnt), 8'h5);
    #3;
    reset = 1'b1;
    #1;
    chk("p5_rst_pe", 8'(pe), 8'h0);
    chk("p5_rst_tmo", 8'(tmo), 8'h0);
    chk("p5_rst_cnt", 8'(dut.cnt), 8'h0);
    tick();
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("p5_post_ea", 8'(ea), 8'h0);
      chk("p5_post_pe", 8'(pe), 8'h0);
    end
    press_pulse();
    chk("p5_pe_a2", 8'(pe), 8'h1);
    tick();
    chk("p5_ea_a2", 8'(ea), 8'h1);
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("p5_a2_tmo", 8'(tmo), 8'h0);
    end
    tick();
    chk("p5_tmo_a2_4", 8'(tmo), 8'h1);
    tick();
    chk("p5_ea_b2", 8'(ea), 8'h2);

    // 6: narrow counter saturates in C without wrapping
    botao2 = 1'b1;
    tick();
    botao2 = 1'b0;
    tick();
    chk("p6_pe_a", 8'(pe2), 8'h1);
    botao2 = 1'b1;
    tick();
    chk("p6_ea_a", 8'(ea2), 8'h1);
    botao2 = 1'b0;
    tick();
    chk("p6_pe_c", 8'(pe2), 8'h3);
    tick();
    chk("p6_ea_c", 8'(ea2), 8'h3);
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("p6_c_ea", 8'(ea2), 8'h3);
      chk("p6_c_tmo", 8'(tmo2), 8'h0);
    end
    chk("p6_cnt_sat", 8'(dut2.cnt), 8'h7);
    botao2 = 1'b1;
    tick();
    botao2 = 1'b0;
    tick();
    chk("p6_pe_idle", 8'(pe2), 8'h0);
    tick();
    chk("p6_ea_idle", 8'(ea2), 8'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/prox_estado.md
# prox_estado

Next-state generator for the 2-bit control FSM. It sits directly upstream of the 2-bit state register and drives that register's `pe0`/`pe1` inputs. The register's `ea0`/`ea1` outputs loop back into this block. The block synchronizes and edge-detects the push-button, synchronizes the abort line and runs a per-state dwell timer, then decodes the next state from the current state and these events.

## Interface
- `T_A`, default 4: cycles spent in state A before its timeout; 1 ≤ T_A ≤ 2^CW−1.
- `T_B`, default 8: cycles spent in state B before its timeout; 1 ≤ T_B ≤ 2^CW−1.
- `CW`, default 8: dwell counter width.
- `clock` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high; clears every flop in the block.
- `botao` in 1: asynchronous push-button level.
- `cancela` in 1: asynchronous abort level.
- `ea0` in 1: current state bit 0, from the state register.
- `ea1` in 1: current state bit 1, from the state register.
- `pe0` out 1: next state bit 0, to the state register.
- `pe1` out 1: next state bit 1, to the state register.
- `tmo` out 1: one-cycle pulse when the dwell timer expires in A or B.

## Operation
- **State encoding `{ea1,ea0}`**: IDLE=00, A=01, B=10, C=11.
- **Button path**: 3 flops `b1→b2→b3`, reset 0. `edge = b2 & ~b3`, high for exactly one cycle per rising `botao`.
- **Abort path**: 2 flops `c1→c2`, reset 0. `cancela_s = c2` (level).
- **Dwell timer**:
  - `ea_prev` is a 2-bit register, reset 00, loaded with `{ea1,ea0}` every cycle.
  - `entry = ({ea1,ea0} != ea_prev)`.
  - `dwell = entry ? 0 : cnt`.
  - `cnt <= dwell+1`, saturating at 2^CW−1; reset 0.
  - `dwell` equals n−1 in the n-th cycle spent in a state.
- **Timeout**: `tmo = (A & dwell==T_A−1) | (B & dwell==T_B−1)`; combinational; always 0 in IDLE and C.
- **Next-state decode** (combinational, priority top-down):
  - `reset` high → 00.
  - `cancela_s` high → 00. Edges and timeouts are ignored while it is high.
  - IDLE: `edge` → A; else IDLE.
  - A: `edge` → C; else `tmo` → B; else A. Edge wins over a simultaneous timeout.
  - B: `edge` → A; else `tmo` → C; else B.
  - C: `edge` → IDLE; else C. C holds indefinitely.
- **Illegal inputs**: none; all four encodings are decoded.
- **Loopback requirement**: the block produces the correct sequence only when `ea` is `pe` registered one cycle later. Behaviour is undefined for arbitrary `ea` sequences, except that `entry` restarts the timer on any `ea` change.

## Timing
- **Reset values**: `pe0`=`pe1`=0 and `tmo`=0 while `reset` is high, independent of `ea` and of the clock. Internal flops are cleared asynchronously; `cnt`=0 and `ea_prev`=00 after reset.
- **Button latency**:
  - `botao` is first sampled high at edge k.
  - `edge` is high between edges k+1 and k+2.
  - `pe` shows the new state in that cycle; the state register captures it at edge k+2.
- **Abort latency**: `cancela` sampled high at edge k → `pe`=00 from edge k+1 → `ea`=00 at edge k+2.
- **Dwell in A and B**:
  - Entering A at edge e gives `tmo` high in cycle T_A, i.e. between edges e+T_A−1 and e+T_A.
  - `ea` becomes B at edge e+T_A, so exactly T_A cycles are spent in A. Same rule for B with T_B.
- **Re-entry**: the timer restarts only on a state change. Staying in a state never retriggers `tmo`, because `cnt` saturates and never wraps.
- **Mid-operation reset**: a reset asserted while in A or B drops `pe` and `tmo` immediately. `cnt` is 0 on release, and no stale `edge` fires after release.
- **Long press**: a `botao` held for many cycles produces exactly one `edge`.

## Test plan
1. Reset, then `botao`=`cancela`=0 for 20 cycles, with the bench modelling the state register → `pe`=00 throughout, `tmo`=0.
2. `botao` first sampled high at edge 10 and held 5 cycles, T_A=4, T_B=8 → `edge` in cycle 11→12 and `ea`=A at edge 12. `tmo` pulses once between edges 15 and 16, then `ea`=B at 16, `ea`=C at 24. `ea` stays C for the next 40 cycles.
3. In A, `botao` edge landing in dwell cycle 2 → `ea`=C on the next edge and `tmo` never asserts. In A, `edge` coincident with dwell cycle 4 (T_A=4) → `ea`=C, not B.
4. In B at dwell cycle 3, `cancela` first sampled high at edge k → `pe`=00 from k+1 and `ea`=00 at k+2. `botao` pulses while `cancela` is high leave `ea` at 00.
5. Reset asserted asynchronously mid-clock while in B with `cnt`=5 → `pe`=00 and `tmo`=0 in the same cycle, before the next edge. After release, `ea` holds 00 for 10 cycles, and a fresh button press enters A with full T_A dwell.
6. CW=3, T_A=7, `ea` held in C for 20 cycles, then a `botao` edge → `cnt` saturates at 7 without wrapping and `tmo` stays 0. `ea`=IDLE two edges after the press.
